// File: rtl/ad9958_sweep_gen.sv
// ad9958_sweep_gen: stepped linear FTW sweep (single up-sweep or continuous
// triangle) that drives the ftw/asf inputs of the AD9958 master core.
// Optional feature: define AD9958_SWEEP_MUTE_EN to force both amplitude
// outputs to zero whenever the generator is idle.
module ad9958_sweep_gen #(
    parameter int FTW_W   = 32,
    parameter int ASF_W   = 10,
    parameter int DWELL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [FTW_W-1:0]   ftw_start,
    input  logic [FTW_W-1:0]   ftw_stop,
    input  logic [FTW_W-1:0]   ftw_step,
    input  logic [FTW_W-1:0]   ftw_offset,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ASF_W-1:0]   asf_in,
    output logic [FTW_W-1:0]   ftw_ch0,
    output logic [FTW_W-1:0]   ftw_ch1,
    output logic [ASF_W-1:0]   asf_ch0,
    output logic [ASF_W-1:0]   asf_ch1,
    output logic               busy,
    output logic               done,
    output logic               tick
);

    typedef enum logic [1:0] {
        IDLE,
        DWELL_UP,
        DWELL_DN
    } state_t;

    state_t             state;
    state_t             state_n;

    logic [FTW_W-1:0]   start_q;
    logic [FTW_W-1:0]   stop_q;
    logic [FTW_W-1:0]   step_q;
    logic [FTW_W-1:0]   offset_q;
    logic               mode_q;
    logic [DWELL_W-1:0] reload_q;

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_n;
    logic [DWELL_W-1:0] dwell_m1;

    logic [FTW_W:0]     up_sum;
    logic [FTW_W:0]     dn_diff;
    logic [FTW_W-1:0]   up_val;
    logic [FTW_W-1:0]   dn_val;
    logic               degen;

    logic [FTW_W-1:0]   ftw0_n;
    logic [FTW_W-1:0]   ftw1_n;
    logic [ASF_W-1:0]   asf_n;
    logic               load;
    logic               busy_n;
    logic               done_n;
    logic               tick_n;

    // A dwell of zero behaves like one; the counter runs from dwell-1 down to 0.
    assign dwell_m1 = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

    // Next ramp values with carry/borrow kept so overshoot clamps to the endpoint.
    assign up_sum  = {1'b0, ftw_ch0} + {1'b0, step_q};
    assign dn_diff = {1'b0, ftw_ch0} - {1'b0, step_q};
    assign up_val  = (up_sum[FTW_W] || (up_sum[FTW_W-1:0] >= stop_q)) ? stop_q : up_sum[FTW_W-1:0];
    assign dn_val  = (dn_diff[FTW_W] || (dn_diff[FTW_W-1:0] <= start_q)) ? start_q : dn_diff[FTW_W-1:0];
    assign degen   = (start_q >= stop_q);

    // Next-state and next-output logic; every output value is registered below.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ftw0_n  = ftw_ch0;
        asf_n   = asf_ch0;
        load    = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load    = 1'b1;
                    state_n = DWELL_UP;
                    ftw0_n  = ftw_start;
                    asf_n   = asf_in;
                    cnt_n   = dwell_m1;
                end
            end
            DWELL_UP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else begin
                    cnt_n = reload_q;
                    if (degen || ((step_q == '0) && mode_q)) begin
                        // Nothing to sweep: single finishes, triangle just holds start.
                        if (!mode_q) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else if (ftw_ch0 == stop_q) begin
                        if (mode_q) begin
                            state_n = DWELL_DN;
                            ftw0_n  = dn_val;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else if (step_q == '0) begin
                        ftw0_n = stop_q;
                    end else begin
                        ftw0_n = up_val;
                    end
                end
            end
            DWELL_DN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else begin
                    cnt_n = reload_q;
                    if (ftw_ch0 == start_q) begin
                        state_n = DWELL_UP;
                        ftw0_n  = up_val;
                    end else begin
                        ftw0_n  = dn_val;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
        tick_n = load || (ftw0_n != ftw_ch0);
        ftw1_n = load ? (ftw_start + ftw_offset) : (ftw0_n + offset_q);
`ifdef AD9958_SWEEP_MUTE_EN
        if (busy && !busy_n) begin
            asf_n  = '0;
            tick_n = 1'b1;
        end
`endif
    end

    // State, dwell counter, latched configuration and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            offset_q <= '0;
            mode_q   <= 1'b0;
            reload_q <= '0;
            ftw_ch0  <= '0;
            ftw_ch1  <= '0;
            asf_ch0  <= '0;
            asf_ch1  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ftw_ch0 <= ftw0_n;
            ftw_ch1 <= ftw1_n;
            asf_ch0 <= asf_n;
            asf_ch1 <= asf_n;
            busy    <= busy_n;
            done    <= done_n;
            tick    <= tick_n;
            if (load) begin
                start_q  <= ftw_start;
                stop_q   <= ftw_stop;
                step_q   <= ftw_step;
                offset_q <= ftw_offset;
                mode_q   <= mode;
                reload_q <= dwell_m1;
            end
        end
    end

endmodule

// File: tb/tb_ad9958_sweep_gen.sv
// tb_ad9958_sweep_gen: directed and randomized sweeps checked cycle by cycle
// against a value-list model of the sweep generator.
module tb_ad9958_sweep_gen;

`ifdef AD9958_SWEEP_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mode;
    logic [31:0] ftw_start;
    logic [31:0] ftw_stop;
    logic [31:0] ftw_step;
    logic [31:0] ftw_offset;
    logic [15:0] dwell;
    logic [9:0]  asf_in;
    logic [31:0] ftw_ch0;
    logic [31:0] ftw_ch1;
    logic [9:0]  asf_ch0;
    logic [9:0]  asf_ch1;
    logic        busy;
    logic        done;
    logic        tick;

    int tests = 0;
    int fails = 0;

    logic [31:0] cfg_start;
    logic [31:0] cfg_stop;
    logic [31:0] cfg_step;
    logic [31:0] cfg_off;
    logic [15:0] cfg_dwell;
    logic        cfg_mode;
    logic [9:0]  cfg_asf;

    logic [31:0] exp_ftw[$];
    bit          exp_tick[$];
    bit          exp_busy[$];
    bit          exp_done[$];
    int          abort_idx;
    int          poke_idx;

    ad9958_sweep_gen #(.FTW_W(32), .ASF_W(10), .DWELL_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .ftw_start(ftw_start), .ftw_stop(ftw_stop), .ftw_step(ftw_step),
        .ftw_offset(ftw_offset), .dwell(dwell), .asf_in(asf_in),
        .ftw_ch0(ftw_ch0), .ftw_ch1(ftw_ch1), .asf_ch0(asf_ch0), .asf_ch1(asf_ch1),
        .busy(busy), .done(done), .tick(tick)
    );

    always #5 clock = ~clock;

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOne(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s %s observed=%0h expected=%0h", tag, what, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] e_ftw, input bit e_tick, input bit e_busy, input bit e_done);
        logic [31:0] e_ftw1;
        logic [9:0]  e_asf;
        e_ftw1 = e_ftw + cfg_off;
        e_asf  = (MUTE && !e_busy) ? 10'h0 : cfg_asf;
        checkOne(tag, "ftw_ch0", ftw_ch0, e_ftw);
        checkOne(tag, "ftw_ch1", ftw_ch1, e_ftw1);
        checkOne(tag, "asf_ch0", 32'(asf_ch0), 32'(e_asf));
        checkOne(tag, "asf_ch1", 32'(asf_ch1), 32'(e_asf));
        checkOne(tag, "busy", 32'(busy), 32'(e_busy));
        checkOne(tag, "done", 32'(done), 32'(e_done));
        checkOne(tag, "tick", 32'(tick), 32'(e_tick));
    endtask

    task automatic checkZero(input string tag);
        checkOne(tag, "ftw_ch0", ftw_ch0, 32'h0);
        checkOne(tag, "ftw_ch1", ftw_ch1, 32'h0);
        checkOne(tag, "asf_ch0", 32'(asf_ch0), 32'h0);
        checkOne(tag, "asf_ch1", 32'(asf_ch1), 32'h0);
        checkOne(tag, "busy", 32'(busy), 32'h0);
        checkOne(tag, "done", 32'(done), 32'h0);
        checkOne(tag, "tick", 32'(tick), 32'h0);
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                                 input logic [31:0] off, input logic [15:0] d, input logic m, input logic [9:0] a);
        cfg_start = s;  ftw_start  = s;
        cfg_stop  = e;  ftw_stop   = e;
        cfg_step  = st; ftw_step   = st;
        cfg_off   = off; ftw_offset = off;
        cfg_dwell = d;  dwell      = d;
        cfg_mode  = m;  mode       = m;
        cfg_asf   = a;  asf_in     = a;
    endtask

    task automatic scrambleInputs();
        ftw_start  = $urandom;
        ftw_stop   = $urandom;
        ftw_step   = $urandom;
        ftw_offset = $urandom;
        dwell      = 16'($urandom);
        mode       = 1'($urandom);
        asf_in     = 10'($urandom);
    endtask

    // Builds the list of emitted values, then expands it into per-cycle expectations.
    task automatic buildModel(input int ncyc);
        logic [31:0] vals[$];
        logic [31:0] v;
        logic [32:0] wide;
        bit          up;
        int          de;
        de = (cfg_dwell == 16'd0) ? 1 : int'(cfg_dwell);
        exp_ftw.delete(); exp_tick.delete(); exp_busy.delete(); exp_done.delete();
        poke_idx  = -1;
        abort_idx = -1;
        v  = cfg_start;
        up = 1'b1;
        vals.push_back(v);
        if (cfg_mode == 1'b0) begin
            if (cfg_start < cfg_stop) begin
                if (cfg_step == 32'd0) begin
                    vals.push_back(cfg_stop);
                end else begin
                    while (v != cfg_stop) begin
                        wide = {1'b0, v} + {1'b0, cfg_step};
                        v = (wide >= {1'b0, cfg_stop}) ? cfg_stop : wide[31:0];
                        vals.push_back(v);
                    end
                end
            end
        end else begin
            while (vals.size() * de < ncyc) begin
                if (cfg_start < cfg_stop && cfg_step != 32'd0) begin
                    if (up) begin
                        wide = {1'b0, v} + {1'b0, cfg_step};
                        v = (wide >= {1'b0, cfg_stop}) ? cfg_stop : wide[31:0];
                        if (v == cfg_stop) up = 1'b0;
                    end else begin
                        if ({1'b0, v} <= ({1'b0, cfg_start} + {1'b0, cfg_step})) v = cfg_start;
                        else v = v - cfg_step;
                        if (v == cfg_start) up = 1'b1;
                    end
                end
                vals.push_back(v);
            end
        end
        for (int i = 0; i < vals.size(); i++) begin
            for (int k = 0; k < de; k++) begin
                bit t;
                t = 1'b0;
                if (k == 0) begin
                    if (i == 0) t = 1'b1;
                    else if (vals[i] != vals[i-1]) t = 1'b1;
                end
                exp_ftw.push_back(vals[i]);
                exp_tick.push_back(t);
                exp_busy.push_back(1'b1);
                exp_done.push_back(1'b0);
            end
        end
        if (cfg_mode == 1'b1) begin
            while (exp_ftw.size() > ncyc) begin
                void'(exp_ftw.pop_back()); void'(exp_tick.pop_back());
                void'(exp_busy.pop_back()); void'(exp_done.pop_back());
            end
            abort_idx = ncyc - 1;
        end
        v = exp_ftw[exp_ftw.size()-1];
        exp_ftw.push_back(v); exp_tick.push_back(MUTE); exp_busy.push_back(1'b0); exp_done.push_back(!cfg_mode);
        exp_ftw.push_back(v); exp_tick.push_back(1'b0); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);
    endtask

    task automatic runSweep(input string tag);
        start = 1'b1;
        abort = 1'b0;
        nextCycle();
        for (int c = 0; c < exp_ftw.size(); c++) begin
            checkOutput($sformatf("%s[%0d]", tag, c), exp_ftw[c], exp_tick[c], exp_busy[c], exp_done[c]);
            start = 1'b0;
            if (c == poke_idx && exp_busy[c]) begin
                start = 1'b1;
                scrambleInputs();
            end
            abort = (c == abort_idx);
            nextCycle();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        logic [31:0] rs;
        logic [31:0] rspan;
        logic [31:0] rst;
        logic [31:0] last;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        applyStimulus(32'd0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 10'd0);
        repeat (3) nextCycle();
        checkZero("reset");
        reset = 1'b0;
        nextCycle();

        applyStimulus(32'd100, 32'd130, 32'd10, 32'd0, 16'd3, 1'b0, 10'h3FF);
        buildModel(0); poke_idx = 4; runSweep("single");

        applyStimulus(32'd0, 32'd25, 32'd10, 32'hFFFFFFF0, 16'd1, 1'b0, 10'h155);
        buildModel(0); runSweep("clamp_off");

        applyStimulus(32'd0, 32'd20, 32'd10, 32'd3, 16'd2, 1'b1, 10'h3FF);
        buildModel(7); poke_idx = 3; runSweep("tri_abort");

        applyStimulus(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 32'd5, 16'd2, 1'b0, 10'h2A);
        buildModel(0); runSweep("overflow");

        applyStimulus(32'd50, 32'd90, 32'd0, 32'd1, 16'd2, 1'b0, 10'h111);
        buildModel(0); runSweep("step0_single");

        applyStimulus(32'd50, 32'd90, 32'd0, 32'd1, 16'd1, 1'b1, 10'h222);
        buildModel(6); runSweep("step0_tri");

        applyStimulus(32'd500, 32'd400, 32'd7, 32'd9, 16'd3, 1'b0, 10'h0F0);
        buildModel(0); runSweep("degen_single");

        applyStimulus(32'd400, 32'd400, 32'd7, 32'd9, 16'd1, 1'b1, 10'h0F0);
        buildModel(5); runSweep("degen_tri");

        applyStimulus(32'd10, 32'd40, 32'd10, 32'd100, 16'd0, 1'b0, 10'h3FF);
        buildModel(0); poke_idx = 1; runSweep("dwell0");

        last  = exp_ftw[exp_ftw.size()-1];
        start = 1'b1; abort = 1'b1;
        nextCycle();
        start = 1'b0; abort = 1'b0;
        checkOutput("start_abort", last, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("start_abort_after", last, 1'b0, 1'b0, 1'b0);

        applyStimulus(32'd1000, 32'd2000, 32'd100, 32'd7, 16'd4, 1'b1, 10'h3FF);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        repeat (5) nextCycle();
        reset = 1'b1;
        nextCycle();
        checkZero("reset_mid");
        reset = 1'b0;
        nextCycle();

        for (int r = 0; r < 8; r++) begin
            rs    = $urandom;
            rspan = $urandom_range(0, 3000);
            rst   = $urandom_range(rspan / 8 + 1, rspan + 50);
            applyStimulus(rs, rs + rspan, rst, $urandom, 16'($urandom_range(0, 4)), 1'(r % 2), 10'($urandom));
            buildModel(int'($urandom_range(4, 40)));
            poke_idx = 2;
            runSweep($sformatf("random%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
